// File: rtl/decode_stage_nway.sv
// N-way RV64 decode stage: per-lane combinational decode feeding a registered
// output stage with a one-group skid buffer for full valid/ready decoupling.

module decode_lane #(
  parameter int XLEN = 64
) (
  input  logic            en,
  input  logic [31:0]     inst,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic            rs1_re,
  output logic            rs2_re,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic [XLEN-1:0] imm,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [5:0]      shamt,
  output logic            mul,
  output logic            illegal
);
  localparam logic [6:0] OP_LUI    = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL    = 7'b1101111, OP_JALR  = 7'b1100111,
                         OP_BRANCH = 7'b1100011, OP_LOAD  = 7'b0000011,
                         OP_STORE  = 7'b0100011, OP_IMM   = 7'b0010011,
                         OP_OP     = 7'b0110011, OP_SYS   = 7'b1110011,
                         OP_IMM32  = 7'b0011011, OP_OP32  = 7'b0111011,
                         OP_AMO    = 7'b0101111, OP_FP    = 7'b1010011;

  logic [6:0]         op;
  logic [2:0]         f3;
  logic               known, sys_nz, wr_op;
  logic signed [31:0] imm32;

  always_comb begin
    op     = inst[6:0];
    f3     = inst[14:12];
    known  = en && (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                               OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_SYS,
                               OP_IMM32, OP_OP32, OP_AMO, OP_FP});
    sys_nz = (f3 != 3'b000);

    rs1_re = known && !(op inside {OP_LUI, OP_AUIPC, OP_JAL}) && !(op == OP_SYS && !sys_nz);
    rs2_re = known && (op inside {OP_BRANCH, OP_STORE, OP_OP, OP_OP32, OP_AMO, OP_FP});
    rs1_addr = rs1_re ? inst[19:15] : 5'd0;
    rs2_addr = rs2_re ? inst[24:20] : 5'd0;

    // mul ops keep their rd field but never write through this path
    mul     = known && (op inside {OP_OP, OP_OP32}) && (inst[31:25] == 7'b0000001);
    wr_op   = known && !(op inside {OP_BRANCH, OP_STORE}) && !(op == OP_SYS && !sys_nz);
    rd_addr = wr_op ? inst[11:7] : 5'd0;
    rd_we   = wr_op && !mul && (rd_addr != 5'd0);

    imm32 = '0;
    if (known) begin
      case (op)
        OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYS:
          imm32 = {{20{inst[31]}}, inst[31:20]};
        OP_STORE:
          imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        OP_BRANCH:
          imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        OP_LUI, OP_AUIPC:
          imm32 = {inst[31:12], 12'b0};
        OP_JAL:
          imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        default: imm32 = '0;
      endcase
    end
    imm = XLEN'(imm32);

    shamt = '0;
    if (en && op == OP_IMM &&
        ((f3 == 3'b001 && inst[31:26] == 6'b000000) ||
         (f3 == 3'b101 && (inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000))))
      shamt = inst[25:20];

    opcode  = en ? op          : 7'd0;
    funct3  = en ? f3          : 3'd0;
    funct7  = en ? inst[31:25] : 7'd0;
    illegal = en && ((inst[1:0] != 2'b11) || !known);
  end
endmodule

module decode_stage_nway #(
  parameter int WAYS  = 2,
  parameter int XLEN  = 64,
  parameter int PID_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WAYS-1:0]       way_mask_i,
  input  logic [WAYS*PID_W-1:0] pID_i,
  input  logic [WAYS*32-1:0]    inst_i,
  input  logic [WAYS*32-1:0]    instAddr_i,
  input  logic [WAYS*XLEN-1:0]  rs1ReadData_i,
  input  logic [WAYS*XLEN-1:0]  rs2ReadData_i,
  output logic [WAYS*5-1:0]     rs1Addr_o,
  output logic [WAYS*5-1:0]     rs2Addr_o,
  output logic [WAYS-1:0]       rs1ReadEnable_o,
  output logic [WAYS-1:0]       rs2ReadEnable_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WAYS-1:0]       way_mask_o,
  output logic [WAYS*PID_W-1:0] pID_o,
  output logic [WAYS*32-1:0]    instAddr_o,
  output logic [WAYS*5-1:0]     rdAddr_o,
  output logic [WAYS-1:0]       rdWriteEnable_o,
  output logic [WAYS*XLEN-1:0]  rs1ReadData_o,
  output logic [WAYS*XLEN-1:0]  rs2ReadData_o,
  output logic [WAYS*XLEN-1:0]  imm_o,
  output logic [WAYS*7-1:0]     opCode_o,
  output logic [WAYS*3-1:0]     funct3_o,
  output logic [WAYS*7-1:0]     funct7_o,
  output logic [WAYS*6-1:0]     shamt_o,
  output logic [WAYS-1:0]       mul_o,
  output logic [WAYS-1:0]       illegal_o
);
  typedef struct packed {
    logic [WAYS-1:0]                way_mask;
    logic [WAYS-1:0][PID_W-1:0]     pid;
    logic [WAYS-1:0][31:0]          pc;
    logic [WAYS-1:0][4:0]           rd;
    logic [WAYS-1:0]                rd_we;
    logic [WAYS-1:0][XLEN-1:0]      rs1_data;
    logic [WAYS-1:0][XLEN-1:0]      rs2_data;
    logic [WAYS-1:0][XLEN-1:0]      imm;
    logic [WAYS-1:0][6:0]           opcode;
    logic [WAYS-1:0][2:0]           funct3;
    logic [WAYS-1:0][6:0]           funct7;
    logic [WAYS-1:0][5:0]           shamt;
    logic [WAYS-1:0]                mul;
    logic [WAYS-1:0]                illegal;
  } grp_t;

  logic [WAYS-1:0][4:0]      l_rd;
  logic [WAYS-1:0]           l_we, l_mul, l_ill;
  logic [WAYS-1:0][XLEN-1:0] l_imm;
  logic [WAYS-1:0][6:0]      l_op, l_f7;
  logic [WAYS-1:0][2:0]      l_f3;
  logic [WAYS-1:0][5:0]      l_sh;

  grp_t dec, out_q, skid_q;
  logic out_v, skid_v, acc, xfer;

  for (genvar g = 0; g < WAYS; g++) begin : g_lane
    decode_lane #(.XLEN(XLEN)) u_lane (
      .en       (way_mask_i[g]),
      .inst     (inst_i[g*32 +: 32]),
      .rs1_addr (rs1Addr_o[g*5 +: 5]),
      .rs2_addr (rs2Addr_o[g*5 +: 5]),
      .rs1_re   (rs1ReadEnable_o[g]),
      .rs2_re   (rs2ReadEnable_o[g]),
      .rd_addr  (l_rd[g]),
      .rd_we    (l_we[g]),
      .imm      (l_imm[g]),
      .opcode   (l_op[g]),
      .funct3   (l_f3[g]),
      .funct7   (l_f7[g]),
      .shamt    (l_sh[g]),
      .mul      (l_mul[g]),
      .illegal  (l_ill[g])
    );
  end

  always_comb begin
    dec          = '0;
    dec.way_mask = way_mask_i;
    dec.pid      = pID_i;
    dec.pc       = instAddr_i;
    dec.rd       = l_rd;
    dec.rd_we    = l_we;
    dec.rs1_data = rs1ReadData_i;
    dec.rs2_data = rs2ReadData_i;
    dec.imm      = l_imm;
    dec.opcode   = l_op;
    dec.funct3   = l_f3;
    dec.funct7   = l_f7;
    dec.shamt    = l_sh;
    dec.mul      = l_mul;
    dec.illegal  = l_ill;
  end

  // ready depends only on state, so ready_i never reaches ready_o combinationally
  assign ready_o = ~skid_v;
  assign acc     = valid_i & ready_o & ~flush_i;
  assign xfer    = out_v & ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (xfer || !out_v) begin
      // OUT is free this cycle: the older skid group always goes first
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (acc) begin
        out_q <= dec;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (acc) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign valid_o         = out_v;
  assign way_mask_o      = out_q.way_mask;
  assign pID_o           = out_q.pid;
  assign instAddr_o      = out_q.pc;
  assign rdAddr_o        = out_q.rd;
  assign rdWriteEnable_o = out_q.rd_we;
  assign rs1ReadData_o   = out_q.rs1_data;
  assign rs2ReadData_o   = out_q.rs2_data;
  assign imm_o           = out_q.imm;
  assign opCode_o        = out_q.opcode;
  assign funct3_o        = out_q.funct3;
  assign funct7_o        = out_q.funct7;
  assign shamt_o         = out_q.shamt;
  assign mul_o           = out_q.mul;
  assign illegal_o       = out_q.illegal;
endmodule

// File: tb/tb_decode_stage_nway.sv
// Directed bench for decode_stage_nway (WAYS=2): decode vector table plus
// stall/skid ordering, flush and mid-stream reset sequences.

module tb_decode_stage_nway;
  localparam int WAYS = 2, XLEN = 64, PID_W = 2;

  logic clk = 0, rst = 1, flush_i = 0, valid_i = 0, ready_i = 0;
  logic ready_o, valid_o;
  logic [WAYS-1:0]       way_mask_i = '0, way_mask_o;
  logic [WAYS*PID_W-1:0] pID_i = '0, pID_o;
  logic [WAYS*32-1:0]    inst_i = '0, instAddr_i = '0, instAddr_o;
  logic [WAYS*XLEN-1:0]  rs1ReadData_i, rs2ReadData_i, rs1ReadData_o, rs2ReadData_o, imm_o;
  logic [WAYS*5-1:0]     rs1Addr_o, rs2Addr_o, rdAddr_o;
  logic [WAYS-1:0]       rs1ReadEnable_o, rs2ReadEnable_o, rdWriteEnable_o, mul_o, illegal_o;
  logic [WAYS*7-1:0]     opCode_o, funct7_o;
  logic [WAYS*3-1:0]     funct3_o;
  logic [WAYS*6-1:0]     shamt_o;

  localparam logic [127:0] RS1 = {64'h2222_3333_4444_5555, 64'h1111_AAAA_BBBB_CCCC};
  localparam logic [127:0] RS2 = {64'h6666_7777_8888_9999, 64'h0123_4567_89AB_CDEF};

  decode_stage_nway #(.WAYS(WAYS), .XLEN(XLEN), .PID_W(PID_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .way_mask_i(way_mask_i), .pID_i(pID_i), .inst_i(inst_i), .instAddr_i(instAddr_i),
    .rs1ReadData_i(rs1ReadData_i), .rs2ReadData_i(rs2ReadData_i),
    .rs1Addr_o(rs1Addr_o), .rs2Addr_o(rs2Addr_o),
    .rs1ReadEnable_o(rs1ReadEnable_o), .rs2ReadEnable_o(rs2ReadEnable_o),
    .valid_o(valid_o), .ready_i(ready_i), .way_mask_o(way_mask_o), .pID_o(pID_o),
    .instAddr_o(instAddr_o), .rdAddr_o(rdAddr_o), .rdWriteEnable_o(rdWriteEnable_o),
    .rs1ReadData_o(rs1ReadData_o), .rs2ReadData_o(rs2ReadData_o), .imm_o(imm_o),
    .opCode_o(opCode_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .shamt_o(shamt_o),
    .mul_o(mul_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_grp(input logic v, input logic [1:0] m, input logic [31:0] i0,
                           input logic [31:0] i1, input logic [31:0] pc);
    valid_i    = v;
    way_mask_i = m;
    inst_i     = {i1, i0};
    instAddr_i = {pc + 32'd4, pc};
    pID_i      = {2'd1, 2'd0};
  endtask

  task automatic chk_out(input string nm, input logic v, input logic r, input logic [31:0] pc);
    chk({nm, ".valid"}, 64'(valid_o), 64'(v));
    chk({nm, ".ready"}, 64'(ready_o), 64'(r));
    chk({nm, ".pc"}, 64'(instAddr_o[31:0]), 64'(pc));
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] imm;
    logic [4:0]  rs1a, rs2a;
    logic        re1, re2, mul, ill;
    logic [5:0]  sh;
  } lane_t;

  typedef struct {
    logic [1:0] mask;
    lane_t      ln [2];
  } vec_t;

  localparam logic [31:0] I_ADDI = 32'h00510093, I_LUI = 32'h123452B7;
  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin
    lane_t addi, lui, beq, mulx, nop0, slli, zro, f7f, srai, lw, jal, ecall, auipc, mz, m7f, mlui;
    addi  = '{I_ADDI,        5'd1,  1'b1, 64'd5,                   5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
    lui   = '{I_LUI,         5'd5,  1'b1, 64'h12345000,            5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    beq   = '{32'hFE208EE3,  5'd0,  1'b0, 64'hFFFFFFFFFFFFFFFC,    5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    mulx  = '{32'h022081B3,  5'd3,  1'b0, 64'd0,                   5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0};
    nop0  = '{32'h00000013,  5'd0,  1'b0, 64'd0,                   5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
    slli  = '{32'h00509193,  5'd3,  1'b1, 64'd5,                   5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5};
    zro   = '{32'h00000000,  5'd0,  1'b0, 64'd0,                   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0};
    f7f   = '{32'h0000007F,  5'd0,  1'b0, 64'd0,                   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0};
    srai  = '{32'h40325213,  5'd4,  1'b1, 64'h403,                 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3};
    lw    = '{32'hFF83A303,  5'd6,  1'b1, 64'hFFFFFFFFFFFFFFF8,    5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
    jal   = '{32'h008000EF,  5'd1,  1'b1, 64'd8,                   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    ecall = '{32'h00000073,  5'd0,  1'b0, 64'd0,                   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    auipc = '{32'hFFFFF517,  5'd10, 1'b1, 64'hFFFFFFFFFFFFF000,    5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    // masked-out lanes: everything decoded is zero whatever the instruction
    mz    = '{I_ADDI,        5'd0,  1'b0, 64'd0,                   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    m7f   = '{32'h0000007F,  5'd0,  1'b0, 64'd0,                   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    mlui  = '{I_LUI,         5'd0,  1'b0, 64'd0,                   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    vecs[0] = '{2'b11, '{addi, lui}};
    vecs[1] = '{2'b11, '{beq, mulx}};
    vecs[2] = '{2'b11, '{nop0, slli}};
    vecs[3] = '{2'b01, '{zro, m7f}};
    vecs[4] = '{2'b11, '{zro, f7f}};
    vecs[5] = '{2'b10, '{mz, srai}};
    vecs[6] = '{2'b11, '{lw, jal}};
    vecs[7] = '{2'b11, '{ecall, auipc}};
    vecs[8] = '{2'b00, '{mz, mlui}};

    rs1ReadData_i = RS1;
    rs2ReadData_i = RS2;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk_out("reset", 1'b0, 1'b1, 32'd0);
    chk("reset.imm", imm_o[63:0], 64'd0);

    ready_i = 1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_grp(1'b1, vecs[i].mask, vecs[i].ln[0].inst, vecs[i].ln[1].inst, 32'h1000 + 32'(i * 8));
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("v%0d.l%0d.rs1a", i, k), 64'(rs1Addr_o[k*5 +: 5]), 64'(vecs[i].ln[k].rs1a));
        chk($sformatf("v%0d.l%0d.rs2a", i, k), 64'(rs2Addr_o[k*5 +: 5]), 64'(vecs[i].ln[k].rs2a));
        chk($sformatf("v%0d.l%0d.re1", i, k), 64'(rs1ReadEnable_o[k]), 64'(vecs[i].ln[k].re1));
        chk($sformatf("v%0d.l%0d.re2", i, k), 64'(rs2ReadEnable_o[k]), 64'(vecs[i].ln[k].re2));
      end
      @(negedge clk);
      valid_i = 0;
      chk($sformatf("v%0d.valid", i), 64'(valid_o), 64'd1);
      chk($sformatf("v%0d.mask", i), 64'(way_mask_o), 64'(vecs[i].mask));
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("v%0d.l%0d.rd", i, k), 64'(rdAddr_o[k*5 +: 5]), 64'(vecs[i].ln[k].rd));
        chk($sformatf("v%0d.l%0d.we", i, k), 64'(rdWriteEnable_o[k]), 64'(vecs[i].ln[k].we));
        chk($sformatf("v%0d.l%0d.imm", i, k), imm_o[k*64 +: 64], vecs[i].ln[k].imm);
        chk($sformatf("v%0d.l%0d.mul", i, k), 64'(mul_o[k]), 64'(vecs[i].ln[k].mul));
        chk($sformatf("v%0d.l%0d.ill", i, k), 64'(illegal_o[k]), 64'(vecs[i].ln[k].ill));
        chk($sformatf("v%0d.l%0d.sh", i, k), 64'(shamt_o[k*6 +: 6]), 64'(vecs[i].ln[k].sh));
        chk($sformatf("v%0d.l%0d.op", i, k), 64'(opCode_o[k*7 +: 7]),
            vecs[i].mask[k] ? 64'(vecs[i].ln[k].inst[6:0]) : 64'd0);
        if (vecs[i].mask[k]) begin
          chk($sformatf("v%0d.l%0d.rs1d", i, k), rs1ReadData_o[k*64 +: 64], RS1[k*64 +: 64]);
          chk($sformatf("v%0d.l%0d.rs2d", i, k), rs2ReadData_o[k*64 +: 64], RS2[k*64 +: 64]);
        end
      end
    end

    // stall with A in OUT and B in SKID, C held off until drain
    @(negedge clk);
    ready_i = 0;
    drive_grp(1'b1, 2'b11, I_ADDI, I_LUI, 32'hA00);
    @(negedge clk);
    chk_out("stall.A0", 1'b1, 1'b1, 32'hA00);
    drive_grp(1'b1, 2'b11, I_ADDI, I_LUI, 32'hB00);
    @(negedge clk);
    chk_out("stall.A1", 1'b1, 1'b0, 32'hA00);
    drive_grp(1'b1, 2'b11, I_ADDI, I_LUI, 32'hC00);
    @(negedge clk);
    chk_out("stall.A2", 1'b1, 1'b0, 32'hA00);
    chk("stall.A2.imm", imm_o[63:0], 64'd5);
    ready_i = 1;
    @(negedge clk);
    chk_out("drain.B", 1'b1, 1'b1, 32'hB00);
    @(negedge clk);
    chk_out("drain.C", 1'b1, 1'b1, 32'hC00);
    valid_i = 0;
    @(negedge clk);
    chk("drain.empty", 64'(valid_o), 64'd0);

    // flush with both entries full and a group presented
    ready_i = 0;
    drive_grp(1'b1, 2'b11, I_ADDI, I_LUI, 32'hA00);
    @(negedge clk);
    drive_grp(1'b1, 2'b11, I_ADDI, I_LUI, 32'hB00);
    @(negedge clk);
    chk("flush.pre.ready", 64'(ready_o), 64'd0);
    drive_grp(1'b1, 2'b11, I_ADDI, I_LUI, 32'hD00);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    valid_i = 0;
    ready_i = 1;
    chk("flush.valid", 64'(valid_o), 64'd0);
    chk("flush.ready", 64'(ready_o), 64'd1);
    @(negedge clk);
    chk("flush.after", 64'(valid_o), 64'd0);

    // flush drops a group even while ready_o is high
    drive_grp(1'b1, 2'b11, I_ADDI, I_LUI, 32'hE00);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    valid_i = 0;
    chk("flush2.valid", 64'(valid_o), 64'd0);
    @(negedge clk);
    chk("flush2.after", 64'(valid_o), 64'd0);

    // reset mid-stall discards both held groups and clears payload
    ready_i = 0;
    drive_grp(1'b1, 2'b11, I_ADDI, I_LUI, 32'hA00);
    @(negedge clk);
    drive_grp(1'b1, 2'b11, I_ADDI, I_LUI, 32'hB00);
    @(negedge clk);
    valid_i = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_out("rst.mid", 1'b0, 1'b1, 32'd0);
    chk("rst.imm", imm_o[63:0], 64'd0);
    chk("rst.mask", 64'(way_mask_o), 64'd0);
    chk("rst.rd", 64'(rdAddr_o), 64'd0);
    chk("rst.rs1d", rs1ReadData_o[63:0], 64'd0);
    ready_i = 1;
    @(negedge clk);
    chk("rst.after", 64'(valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
